// File: rtl/switch_ctrl_pkg.sv
// Shared constants for the switch input controller: register addresses and edge-type encodings.
package switch_ctrl_pkg;

   localparam int unsigned ADDR_W = 2;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [ADDR_W-1:0] {
      ADDR_DATA = 2'd0,
      ADDR_RSVD = 2'd1,
      ADDR_MASK = 2'd2,
      ADDR_EDGE = 2'd3
   } addr_e;

   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/switch_input_ctrl_if.sv
// Avalon-MM slave bus plus interrupt line of the switch input controller.
interface switch_input_ctrl_if;
   import switch_ctrl_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic              irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );

endinterface

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-flop synchronizer followed by a tick-driven debounce counter.
// SWITCH_INPUT_CTRL_DEBOUNCE_EN selects the counter; otherwise stable follows the synchronizer.
module switch_debounce_bit #(
   parameter int unsigned DB_TICKS = 10
) (
   input  logic clk,
   input  logic reset,
`ifdef SWITCH_INPUT_CTRL_DEBOUNCE_EN
   input  logic tick,
`endif
   input  logic din,
   output logic stable
);

   if (DB_TICKS < 1) begin : g_bad_db_ticks
      $error("switch_debounce_bit: DB_TICKS must be at least 1");
   end

   logic sync1;
   logic sync2;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

`ifdef SWITCH_INPUT_CTRL_DEBOUNCE_EN
   localparam int unsigned CW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;

   logic [CW-1:0] cnt;

   // Any sample agreeing with stable clears the count, so glitches never accumulate.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (sync2 == stable) begin
         cnt <= '0;
      end else if (tick) begin
         if (cnt == CW'(DB_TICKS - 1)) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) stable <= 1'b0;
      else       stable <= sync2;
   end
`endif

endmodule

// File: rtl/switch_input_ctrl.sv
// Avalon-MM switch/button controller: debounced DATA, IRQ_MASK, W1C EDGE_CAPTURE and level irq.
// SWITCH_INPUT_CTRL_DEBOUNCE_EN builds the prescaler and per-bit debounce counters.
module switch_input_ctrl
   import switch_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned TICK_DIV  = 50000,
   parameter int unsigned DB_TICKS  = 10,
   parameter int unsigned EDGE_TYPE = 0
) (
   input  logic                clk,
   input  logic                reset,
   switch_input_ctrl_if.slave  bus,
   input  logic [WIDTH-1:0]    in_port
);

   if (WIDTH < 1 || WIDTH > DATA_W) begin : g_bad_width
      $error("switch_input_ctrl: WIDTH must be in 1..32");
   end
   if (TICK_DIV < 2) begin : g_bad_tick_div
      $error("switch_input_ctrl: TICK_DIV must be at least 2");
   end
   if (EDGE_TYPE > EDGE_ANY) begin : g_bad_edge_type
      $error("switch_input_ctrl: EDGE_TYPE must be 0, 1 or 2");
   end

   logic [WIDTH-1:0]  stable;
   logic [WIDTH-1:0]  stable_d;
   logic [WIDTH-1:0]  irq_mask;
   logic [WIDTH-1:0]  edge_capture;
   logic [WIDTH-1:0]  rise_c;
   logic [WIDTH-1:0]  fall_c;
   logic [WIDTH-1:0]  edge_c;
   logic [WIDTH-1:0]  clr_c;
   logic [DATA_W-1:0] rdata_c;
   logic [DATA_W-1:0] readdata;
   logic              irq;
   logic              wr_c;
   logic              unused_wdata_c;

`ifdef SWITCH_INPUT_CTRL_DEBOUNCE_EN
   localparam int unsigned PW = $clog2(TICK_DIV);

   logic [PW-1:0] presc;
   logic          tick_c;

   assign tick_c = (presc == PW'(TICK_DIV - 1));

   // Free-running sample-tick prescaler shared by all bits.
   always_ff @(posedge clk) begin
      if (reset)       presc <= '0;
      else if (tick_c) presc <= '0;
      else             presc <= presc + PW'(1);
   end
`endif

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      switch_debounce_bit #(
         .DB_TICKS (DB_TICKS)
      ) u_db (
         .clk    (clk),
         .reset  (reset),
`ifdef SWITCH_INPUT_CTRL_DEBOUNCE_EN
         .tick   (tick_c),
`endif
         .din    (in_port[i]),
         .stable (stable[i])
      );
   end

   assign wr_c           = bus.chipselect & ~bus.write_n;
   assign clr_c          = (wr_c && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;
   assign unused_wdata_c = ^bus.writedata;

   always_comb begin
      rise_c = stable & ~stable_d;
      fall_c = ~stable & stable_d;
      edge_c = rise_c;
      case (EDGE_TYPE)
         EDGE_FALL: edge_c = fall_c;
         EDGE_ANY:  edge_c = rise_c | fall_c;
         default:   edge_c = rise_c;
      endcase
   end

   always_comb begin
      rdata_c = '0;
      case (bus.address)
         ADDR_DATA: rdata_c = DATA_W'(stable);
         ADDR_RSVD: rdata_c = '0;
         ADDR_MASK: rdata_c = DATA_W'(irq_mask);
         ADDR_EDGE: rdata_c = DATA_W'(edge_capture);
         default:   rdata_c = '0;
      endcase
   end

   // A new edge is OR-ed in after the W1C clear, so the set wins on a collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_d     <= '0;
         irq_mask     <= '0;
         edge_capture <= '0;
         readdata     <= '0;
         irq          <= 1'b0;
      end else begin
         stable_d <= stable;
         if (wr_c && bus.address == ADDR_MASK) irq_mask <= bus.writedata[WIDTH-1:0];
         edge_capture <= (edge_capture & ~clr_c) | edge_c;
         readdata     <= rdata_c;
         irq          <= |(edge_capture & irq_mask);
      end
   end

   assign bus.readdata = readdata;
   assign bus.irq      = irq;

endmodule
